// File: rtl/acoustic_pkg.sv
// Shared constants and state encodings for the acoustic capture path.
package acoustic_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 10;
  localparam int FRAME_LEN = 1 << (ADDR_W - 1);

  // Per-bank ownership: free for capture, being filled, or awaiting release.
  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Writer either stores samples or drops them while both banks are held.
  typedef enum logic {
    WR_WRITE = 1'b0,
    WR_STALL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sample_frame_writer.sv
// Ping-pong frame writer: packs PCM samples into two RAM banks of FRAME_LEN
// words each, hands full banks downstream and waits for them to be released.
// Optional build macro SAMPLE_FRAME_WRITER_OVF_CNT_EN adds the saturating
// dropped-sample counter output ovf_cnt.
module sample_frame_writer #(
  parameter int DATA_W = acoustic_pkg::DATA_W,
  parameter int ADDR_W = acoustic_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rel_valid,
  input  logic              rel_bank,
  output logic              wr_ce,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_valid,
  output logic              frame_bank,
  output logic [1:0]        full_mask,
  output logic              overflow
`ifdef SAMPLE_FRAME_WRITER_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_cnt
`endif
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  acoustic_pkg::bank_state_e bank_reg  [2];
  acoustic_pkg::bank_state_e bank_next [2];
  acoustic_pkg::wr_state_e   state_reg, state_next;

  logic              cur_bank_reg, cur_bank_next;
  logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
  logic              other_bank;

  logic              wr_ce_reg, wr_ce_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;
  logic              frame_valid_reg, frame_valid_next;
  logic              frame_bank_reg, frame_bank_next;
  logic              overflow_reg, overflow_next;

  assign other_bank = ~cur_bank_reg;

  // State register: bank ownership, writer position and registered RAM port.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_reg[0]     <= acoustic_pkg::BANK_FILLING;
      bank_reg[1]     <= acoustic_pkg::BANK_FREE;
      state_reg       <= acoustic_pkg::WR_WRITE;
      cur_bank_reg    <= 1'b0;
      wr_idx_reg      <= '0;
      wr_ce_reg       <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      frame_valid_reg <= 1'b0;
      frame_bank_reg  <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      bank_reg[0]     <= bank_next[0];
      bank_reg[1]     <= bank_next[1];
      state_reg       <= state_next;
      cur_bank_reg    <= cur_bank_next;
      wr_idx_reg      <= wr_idx_next;
      wr_ce_reg       <= wr_ce_next;
      wr_addr_reg     <= wr_addr_next;
      wr_data_reg     <= wr_data_next;
      frame_valid_reg <= frame_valid_next;
      frame_bank_reg  <= frame_bank_next;
      overflow_reg    <= overflow_next;
    end
  end

  // Next-state logic: releases are applied first so a bank freed this cycle
  // can immediately receive the next frame.
  always_comb begin
    bank_next[0]     = bank_reg[0];
    bank_next[1]     = bank_reg[1];
    state_next       = state_reg;
    cur_bank_next    = cur_bank_reg;
    wr_idx_next      = wr_idx_reg;
    wr_ce_next       = 1'b0;
    wr_addr_next     = wr_addr_reg;
    wr_data_next     = wr_data_reg;
    frame_valid_next = 1'b0;
    frame_bank_next  = frame_bank_reg;
    overflow_next    = 1'b0;

    // Only a FULL bank can be handed back; anything else is a stray release.
    if (rel_valid && (bank_reg[rel_bank] == acoustic_pkg::BANK_FULL)) begin
      bank_next[rel_bank] = acoustic_pkg::BANK_FREE;
      // While stalled, the bank waiting to be refilled is the one we did not
      // just complete; its release lets capture restart at index 0.
      if ((state_reg == acoustic_pkg::WR_STALL) && (rel_bank == other_bank)) begin
        bank_next[rel_bank] = acoustic_pkg::BANK_FILLING;
        cur_bank_next       = rel_bank;
        wr_idx_next         = '0;
        state_next          = acoustic_pkg::WR_WRITE;
      end
    end

    if (state_reg == acoustic_pkg::WR_WRITE) begin
      if (!enable) begin
        // Capture paused: the partial frame is abandoned, bank stays FILLING.
        wr_idx_next = '0;
      end else if (in_valid) begin
        wr_ce_next   = 1'b1;
        wr_addr_next = {cur_bank_reg, wr_idx_reg};
        wr_data_next = in_data;
        if (wr_idx_reg == LAST_IDX) begin
          wr_idx_next             = '0;
          bank_next[cur_bank_reg] = acoustic_pkg::BANK_FULL;
          frame_valid_next        = 1'b1;
          frame_bank_next         = cur_bank_reg;
          if (bank_next[other_bank] == acoustic_pkg::BANK_FREE) begin
            bank_next[other_bank] = acoustic_pkg::BANK_FILLING;
            cur_bank_next         = other_bank;
          end else begin
            state_next = acoustic_pkg::WR_STALL;
          end
        end else begin
          wr_idx_next = wr_idx_reg + 1'b1;
        end
      end
    end else begin
      // Both banks held downstream: every offered sample is lost.
      overflow_next = enable && in_valid;
    end
  end

  // Expose bank occupancy as a per-bank FULL flag.
  for (genvar gi = 0; gi < 2; gi++) begin : g_full
    assign full_mask[gi] = (bank_reg[gi] == acoustic_pkg::BANK_FULL);
  end

  assign wr_ce       = wr_ce_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_bank  = frame_bank_reg;
  assign overflow    = overflow_reg;

`ifdef SAMPLE_FRAME_WRITER_OVF_CNT_EN
  logic [15:0] ovf_cnt_reg;
  logic        ovf_clr;

  assign ovf_clr = (state_reg == acoustic_pkg::WR_STALL) &&
                   (state_next == acoustic_pkg::WR_WRITE);

  // Saturating drop counter, restarted whenever a stall is resolved.
  always_ff @(posedge clk) begin
    if (reset || ovf_clr) begin
      ovf_cnt_reg <= '0;
    end else if (overflow_next && (ovf_cnt_reg != 16'hFFFF)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
`endif

endmodule
